// File: rtl/detonator_display_if.sv
// detonator_display_if: core-facing status/digit inputs and display/LED/buzzer outputs
interface detonator_display_if;
    logic [3:0] m_disp;
    logic       digit_stb;
    logic       clr;
    logic       lt;
    logic       bt;
    logic       rt;
    logic       lb;
    logic [6:0] seg;
    logic [3:0] an;
    logic       led_g;
    logic       led_y;
    logic       led_r;
    logic       buzzer;
    modport master (
        output m_disp, digit_stb, clr, lt, bt, rt, lb,
        input  seg, an, led_g, led_y, led_r, buzzer
    );
    modport slave (
        input  m_disp, digit_stb, clr, lt, bt, rt, lb,
        output seg, an, led_g, led_y, led_r, buzzer
    );
endinterface

// File: rtl/detonator_display.sv
// detonator_display: 4-digit scanned 7-segment display, status LEDs with blinking
// yellow, and a burst-restarting square-wave buzzer.
module detonator_display #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int TONE_HZ  = 2000,
    parameter int BLINK_HZ = 2
) (
    input logic clk,
    input logic rst,
    detonator_display_if.slave bus
);
    localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int TONE_DIV  = CLK_HZ / (2 * TONE_HZ);
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int TW = $clog2(TONE_DIV + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);
    // index 15 first: F blanks, A-E show a dash
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h7F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    logic [SW-1:0]    scan_cnt;
    logic [TW-1:0]    tone_cnt;
    logic [BW-1:0]    blink_cnt;
    logic [1:0]       sel;
    logic             blink;
    logic [3:0][3:0]  digits;
    logic             scan_wrap, tone_wrap, blink_wrap;

    assign scan_wrap  = scan_cnt == SW'(SCAN_DIV - 1);
    assign tone_wrap  = tone_cnt == TW'(TONE_DIV - 1);
    assign blink_wrap = blink_cnt == BW'(BLINK_DIV - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            digits     <= '1;
            sel        <= '0;
            scan_cnt   <= '0;
            tone_cnt   <= '0;
            blink_cnt  <= '0;
            blink      <= 1'b0;
            bus.seg    <= 7'h7F;
            bus.an     <= 4'hF;
            bus.led_g  <= 1'b0;
            bus.led_y  <= 1'b0;
            bus.led_r  <= 1'b0;
            bus.buzzer <= 1'b0;
        end else begin
            if (bus.clr)
                digits <= '1;
            else if (bus.digit_stb)
                digits <= {digits[2:0], bus.m_disp};
            scan_cnt   <= scan_wrap ? '0 : scan_cnt + 1'b1;
            sel        <= sel + {1'b0, scan_wrap};
            bus.an     <= ~(4'b0001 << sel);
            bus.seg    <= SEG_LUT[digits[sel]];
            blink_cnt  <= blink_wrap ? '0 : blink_cnt + 1'b1;
            blink      <= blink ^ blink_wrap;
            bus.led_g  <= bus.lt;
            bus.led_r  <= bus.rt;
            bus.led_y  <= bus.bt & blink;
            // counter parks at 0 while idle so a burst opens with a full high phase
            tone_cnt   <= (!bus.lb || tone_wrap) ? '0 : tone_cnt + 1'b1;
            bus.buzzer <= bus.lb & (bus.buzzer ^ (tone_cnt == '0));
        end
    end
endmodule

// File: tb/tb_detonator_display.sv
// tb_detonator_display: directed tables and sequences plus randomized traffic,
// all cross-checked against a time-based reference model of the display.
module tb_detonator_display;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    detonator_display_if bus();
    detonator_display #(.CLK_HZ(1000), .SCAN_HZ(100), .TONE_HZ(50), .BLINK_HZ(10))
        dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic [6:0] s;
    } vec_t;
    vec_t       tab [16];
    logic [3:0] an_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            4'hF: return 7'h7F;
            default: return 7'h3F;
        endcase
    endfunction

    // model: t edges since reset release, b consecutive edges with lb high
    int         t, b, s;
    logic [3:0] mb [4];
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_g, e_y, e_r, e_bz;

    always @(posedge clk) begin
        if (rst) begin
            t = 0;
            b = 0;
            foreach (mb[i]) mb[i] = 4'hF;
            e_seg = 7'h7F;
            e_an  = 4'hF;
            e_g   = 1'b0;
            e_y   = 1'b0;
            e_r   = 1'b0;
            e_bz  = 1'b0;
        end else begin
            s     = (t / 10) % 4;
            e_an  = ~(4'b0001 << s);
            e_seg = dec(mb[s]);
            e_g   = bus.lt;
            e_r   = bus.rt;
            e_y   = bus.bt & ((t / 50) % 2 == 1);
            b     = bus.lb ? b + 1 : 0;
            e_bz  = (b > 0) && (((b - 1) / 10) % 2 == 0);
            if (bus.clr)
                foreach (mb[i]) mb[i] = 4'hF;
            else if (bus.digit_stb) begin
                mb[3] = mb[2];
                mb[2] = mb[1];
                mb[1] = mb[0];
                mb[0] = bus.m_disp;
            end
            t++;
        end
    end

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("model_seg", bus.seg, e_seg);
        chk("model_an", 7'(bus.an), 7'(e_an));
        chk("model_led_g", 7'(bus.led_g), 7'(e_g));
        chk("model_led_y", 7'(bus.led_y), 7'(e_y));
        chk("model_led_r", 7'(bus.led_r), 7'(e_r));
        chk("model_buzzer", 7'(bus.buzzer), 7'(e_bz));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic scan_check(input string nm, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        for (int i = 0; i < 40; i++) begin
            tick();
            case (bus.an)
                4'hE: chk({nm, "_d0"}, bus.seg, s0);
                4'hD: chk({nm, "_d1"}, bus.seg, s1);
                4'hB: chk({nm, "_d2"}, bus.seg, s2);
                4'h7: chk({nm, "_d3"}, bus.seg, s3);
                default: chk({nm, "_an_onehot"}, 7'(bus.an), 7'hE);
            endcase
        end
    endtask

    task automatic strobe(input logic [3:0] d);
        bus.digit_stb = 1'b1;
        bus.m_disp    = d;
        tick();
        bus.digit_stb = 1'b0;
    endtask

    initial begin
        int hits, last;
        logic prev;
        tab = '{
            '{4'd0, 7'h40}, '{4'd1, 7'h79}, '{4'd2, 7'h24}, '{4'd3, 7'h30},
            '{4'd4, 7'h19}, '{4'd5, 7'h12}, '{4'd6, 7'h02}, '{4'd7, 7'h78},
            '{4'd8, 7'h00}, '{4'd9, 7'h10}, '{4'hA, 7'h3F}, '{4'hB, 7'h3F},
            '{4'hC, 7'h3F}, '{4'hD, 7'h3F}, '{4'hE, 7'h3F}, '{4'hF, 7'h7F}
        };
        bus.m_disp = 4'd0;
        bus.digit_stb = 1'b0;
        bus.clr = 1'b0;
        bus.lt = 1'b0;
        bus.bt = 1'b0;
        bus.rt = 1'b0;
        bus.lb = 1'b0;

        tick();
        chk("rst_seg", bus.seg, 7'h7F);
        chk("rst_an", 7'(bus.an), 7'hF);
        chk("rst_buzzer", 7'(bus.buzzer), 7'h0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("scan_an", 7'(bus.an), 7'(an_seq[i]));
            chk("scan_blank", bus.seg, 7'h7F);
            repeat (10) tick();
        end

        foreach (tab[i]) begin
            do_reset();
            strobe(tab[i].d);
            tick();
            chk("dec_an", 7'(bus.an), 7'hE);
            chk("dec_seg", bus.seg, tab[i].s);
        end

        do_reset();
        strobe(4'd1);
        strobe(4'd2);
        strobe(4'd3);
        strobe(4'd4);
        repeat (2) tick();
        scan_check("t2", 7'h19, 7'h30, 7'h24, 7'h79);

        strobe(4'd5);
        strobe(4'd6);
        strobe(4'd7);
        strobe(4'd8);
        repeat (2) tick();
        scan_check("t3", 7'h00, 7'h78, 7'h02, 7'h12);
        strobe(4'd12);
        tick();
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.an == 4'hE) begin
                chk("t3_dash", bus.seg, 7'h3F);
                hits++;
            end
        end
        if (hits == 0) chk("t3_dash_seen", 7'd0, 7'd1);

        bus.clr = 1'b1;
        strobe(4'd9);
        bus.clr = 1'b0;
        tick();
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("t4_clr_blank", bus.seg, 7'h7F);
        end

        bus.lb = 1'b1;
        tick();
        chk("bz_first", 7'(bus.buzzer), 7'h1);
        for (int i = 1; i < 45; i++) begin
            tick();
            chk("bz_tone", 7'(bus.buzzer), ((i / 10) % 2 == 0) ? 7'h1 : 7'h0);
        end
        bus.lb = 1'b0;
        tick();
        chk("bz_off", 7'(bus.buzzer), 7'h0);
        repeat (3) tick();
        bus.lb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bz_restart_high", 7'(bus.buzzer), 7'h1);
        end
        tick();
        chk("bz_restart_low", 7'(bus.buzzer), 7'h0);
        bus.lb = 1'b0;
        tick();

        bus.bt = 1'b1;
        bus.lt = 1'b1;
        bus.rt = 1'b0;
        tick();
        chk("led_g_on", 7'(bus.led_g), 7'h1);
        chk("led_r_off", 7'(bus.led_r), 7'h0);
        prev = bus.led_y;
        last = -1;
        hits = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.led_y != prev) begin
                if (last >= 0) begin
                    chk("blink_period", 7'(i - last), 7'd50);
                    hits++;
                end
                last = i;
                prev = bus.led_y;
            end
        end
        if (hits == 0) chk("blink_seen", 7'd0, 7'd1);
        rst = 1'b1;
        tick();
        chk("rst_led_g", 7'(bus.led_g), 7'h0);
        chk("rst_led_y", 7'(bus.led_y), 7'h0);
        chk("rst_led_r", 7'(bus.led_r), 7'h0);
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            bus.digit_stb = ($urandom_range(3) == 0);
            bus.clr       = ($urandom_range(19) == 0);
            bus.m_disp    = 4'($urandom_range(15));
            if ($urandom_range(29) == 0) bus.lb = ~bus.lb;
            if ($urandom_range(39) == 0) bus.lt = ~bus.lt;
            if ($urandom_range(39) == 0) bus.bt = ~bus.bt;
            if ($urandom_range(39) == 0) bus.rt = ~bus.rt;
            rst = ($urandom_range(299) == 0);
            tick();
        end
        rst = 1'b0;
        bus.digit_stb = 1'b0;
        bus.clr = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
